// File: rtl/lcd_spi_monitor.sv
// LCD SPI bus monitor: oversamples SCLK/data/D-C/CS_n, deserializes mode-0 bytes into an AXI4-Stream FIFO.
// Optional pixel packing of D/C=1 byte pairs into 16-bit words: define LCD_SPI_MON_PIXEL_PACK_EN.
module lcd_spi_monitor #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic        spi_sclk,
  input  logic        spi_data,
  input  logic        spi_dc,
  input  logic        spi_cs_n,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic [15:0] m00_axis_tdata,
  output logic [1:0]  m00_axis_tuser,
  output logic [31:0] byte_count,
  output logic [15:0] overflow_count,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       clk;
  logic       rst_n;
  assign clk   = m00_axis_aclk;
  assign rst_n = m00_axis_aresetn;

  // cs_n synchronizer resets low so a bus already mid-frame is never seen as a fresh CS_n fall
  logic [2:0] sclk_q;
  logic [1:0] data_q;
  logic [1:0] dc_q;
  logic [2:0] cs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      data_q <= 2'b00;
      dc_q   <= 2'b00;
      cs_q   <= 3'b000;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      data_q <= {data_q[0], spi_data};
      dc_q   <= {dc_q[0], spi_dc};
      cs_q   <= {cs_q[1:0], spi_cs_n};
    end
  end

  logic sclk_rise;
  logic cs_rise;
  logic cs_fall;
  logic cs_low;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_low    = ~cs_q[1];

  // stage 1: bit capture
  logic        armed_q,      armed_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [6:0]  shift_q,      shift_d;
  logic        byte_vld_q,   byte_vld_d;
  logic [7:0]  byte_q,       byte_d;
  logic        byte_dc_q,    byte_dc_d;
  logic [31:0] byte_count_q, byte_count_d;
  logic        cs_end_q,     cs_end_d;
  logic        partial_q,    partial_d;
  logic        cs_start_q,   cs_start_d;

  always_comb begin
    armed_d      = armed_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_vld_d   = 1'b0;
    byte_d       = byte_q;
    byte_dc_d    = byte_dc_q;
    byte_count_d = byte_count_q;
    cs_end_d     = 1'b0;
    partial_d    = 1'b0;
    cs_start_d   = cs_fall;
    if (cs_fall) begin
      armed_d   = 1'b1;
      bit_cnt_d = 3'd0;
    end
    if (cs_rise) begin
      armed_d   = 1'b0;
      bit_cnt_d = 3'd0;
      cs_end_d  = 1'b1;
      partial_d = (bit_cnt_q != 3'd0);
    end else if (armed_q && cs_low && sclk_rise) begin
      shift_d = {shift_q[5:0], data_q[1]};
      if (bit_cnt_q == 3'd7) begin
        byte_vld_d   = 1'b1;
        byte_d       = {shift_q, data_q[1]};
        byte_dc_d    = dc_q[1];
        byte_count_d = byte_count_q + 32'd1;
        bit_cnt_d    = 3'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_vld_q   <= 1'b0;
      byte_q       <= 8'd0;
      byte_dc_q    <= 1'b0;
      byte_count_q <= 32'd0;
      cs_end_q     <= 1'b0;
      partial_q    <= 1'b0;
      cs_start_q   <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_vld_q   <= byte_vld_d;
      byte_q       <= byte_d;
      byte_dc_q    <= byte_dc_d;
      byte_count_q <= byte_count_d;
      cs_end_q     <= cs_end_d;
      partial_q    <= partial_d;
      cs_start_q   <= cs_start_d;
    end
  end

  // stage 2: word assembly
  logic        wr_en;
  logic [15:0] wr_word;
  logic        wr_dc;
  logic        first_q,     first_d;
  logic        frame_err_q, frame_err_d;

`ifdef LCD_SPI_MON_PIXEL_PACK_EN
  logic       pend_vld_q, pend_vld_d;
  logic [7:0] pend_q,     pend_d;

  always_comb begin
    wr_en       = 1'b0;
    wr_word     = 16'h0000;
    wr_dc       = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_d      = pend_q;
    frame_err_d = 1'b0;
    if (byte_vld_q) begin
      if (!byte_dc_q) begin
        wr_en   = 1'b1;
        wr_word = {8'h00, byte_q};
        if (pend_vld_q) begin
          pend_vld_d  = 1'b0;
          frame_err_d = 1'b1;
        end
      end else if (pend_vld_q) begin
        wr_en      = 1'b1;
        wr_word    = {pend_q, byte_q};
        wr_dc      = 1'b1;
        pend_vld_d = 1'b0;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = byte_q;
      end
    end
    if (cs_end_q) begin
      frame_err_d = frame_err_d | partial_q | pend_vld_d;
      pend_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_q     <= 8'd0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end
`else
  always_comb begin
    wr_en       = byte_vld_q;
    wr_word     = {8'h00, byte_q};
    wr_dc       = byte_dc_q;
    frame_err_d = cs_end_q & partial_q;
  end
`endif

  always_comb begin
    first_d = first_q;
    if (wr_en)      first_d = 1'b0;
    if (cs_start_q) first_d = 1'b1;
  end

  // output FIFO; a read in the same cycle frees the slot a full-FIFO write needs
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [15:0] ovf_q,  ovf_d;
  logic        full;
  logic        empty;
  logic        rd_en;
  logic        wr_ok;
  logic [17:0] rd_word;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign rd_en   = !empty && m00_axis_tready;
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_word = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wr_ok ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d = rd_en ? rptr_q + (AW+1)'(1) : rptr_q;
    ovf_d  = ovf_q;
    if (wr_en && !wr_ok && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q[AW-1:0]] <= {first_q, wr_dc, wr_word};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 16'd0;
      first_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m00_axis_tvalid = !empty;
  assign m00_axis_tdata  = empty ? 16'h0000 : rd_word[15:0];
  assign m00_axis_tuser  = empty ? 2'b00 : rd_word[17:16];
  assign byte_count      = byte_count_q;
  assign overflow_count  = ovf_q;
  assign frame_err       = frame_err_q;

endmodule
